// File: rtl/pool_2_reader_pkg.sv
// Shared definitions for the pool-2 drain reader: FSM encoding, FIFO depth and
// derived counter widths.
package pool_2_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned FifoDepth = 4;

  // Ceiling log2, never below 1 so that a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 1) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

  // Credit and occupancy must represent 0..FifoDepth inclusive.
  localparam int unsigned CreditWidth = clog2(FifoDepth + 1);
  localparam int unsigned PtrWidth    = clog2(FifoDepth);

endpackage

// File: rtl/pool_2_reader_if.sv
// Port-b RAM read channel plus the tagged pixel output stream of the pool-2
// reader. The reader drives through master; RAM and downstream sit on slave.
interface pool_2_reader_if #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned MAP_SEL_WIDTH = 2,
  parameter int unsigned POS_WIDTH     = 3
);

  logic                     rden;
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [DATA_WIDTH-1:0]    q;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [MAP_SEL_WIDTH-1:0] out_map;
  logic [POS_WIDTH-1:0]     out_row;
  logic [POS_WIDTH-1:0]     out_col;
  logic                     out_last_map;
  logic                     out_last;

  modport master (
    output rden, rd_addr, out_data, out_valid, out_map, out_row, out_col,
           out_last_map, out_last,
    input  q, out_ready
  );

  modport slave (
    input  rden, rd_addr, out_data, out_valid, out_map, out_row, out_col,
           out_last_map, out_last,
    output q, out_ready
  );

endinterface

// File: rtl/pool_2_reader_sync_fifo_4.sv
// Four-entry synchronous FIFO with a show-ahead head, used to absorb the RAM
// read latency while the output stream is stalled.
module pool_2_reader_sync_fifo_4
  import pool_2_reader_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0]       mem_q [FifoDepth];
  logic [PtrWidth-1:0]    wptr_q;
  logic [PtrWidth-1:0]    rptr_q;
  logic [CreditWidth-1:0] count_q;
  logic                   do_push;
  logic                   do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(FifoDepth); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + PtrWidth'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrWidth'(1);
      end
      count_q <= count_q + CreditWidth'(do_push) - CreditWidth'(do_pop);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == CreditWidth'(FifoDepth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/pool_2_reader.sv
// Streams NUM_MAPS pooled WxW maps out of the shared RAM via port b, tagging each
// pixel with map/row/col; a credit counter bounds outstanding reads to the FIFO depth.
module pool_2_reader
  import pool_2_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned MAP_WIDTH     = 6,
  parameter int unsigned NUM_MAPS      = 1,
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned MAP_SEL_WIDTH = 2,
  parameter int unsigned POS_WIDTH     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  pool_2_reader_if.master  bus
);

  typedef struct packed {
    logic [MAP_SEL_WIDTH-1:0] map;
    logic [POS_WIDTH-1:0]     row;
    logic [POS_WIDTH-1:0]     col;
    logic                     last_map;
    logic                     last;
  } tag_t;

  localparam int unsigned EntryWidth = DATA_WIDTH + $bits(tag_t);

  state_e                   state_q;
  logic [CreditWidth-1:0]   credit_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [MAP_SEL_WIDTH-1:0] map_q;
  logic [POS_WIDTH-1:0]     row_q;
  logic [POS_WIDTH-1:0]     col_q;
  logic                     rden_q;
  logic [ADDR_WIDTH-1:0]    rd_addr_q;
  tag_t                     rd_tag_q;
  logic                     pipe_valid_q;
  tag_t                     pipe_tag_q;
  logic                     busy_q;
  logic                     done_q;

  tag_t                     cur_tag;
  logic                     issue;
  logic                     pop;
  logic [EntryWidth-1:0]    fifo_rdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_valid;
  logic [DATA_WIDTH-1:0]    head_data;
  tag_t                     head_tag;

  always_comb begin
    cur_tag          = '0;
    cur_tag.map      = map_q;
    cur_tag.row      = row_q;
    cur_tag.col      = col_q;
    cur_tag.last_map = (row_q == POS_WIDTH'(MAP_WIDTH - 1)) &&
                       (col_q == POS_WIDTH'(MAP_WIDTH - 1));
    cur_tag.last     = cur_tag.last_map && (map_q == MAP_SEL_WIDTH'(NUM_MAPS - 1));
  end

  // The read leaves the rden register one cycle after this decision, so the
  // accepting start cycle already commits the read that appears in the first RUN cycle.
  always_comb begin
    issue = 1'b0;
    case (state_q)
      StIdle:  issue = start;
      StRun:   issue = (credit_q != '0) && !fifo_full;
      default: issue = 1'b0;
    endcase
  end

  assign fifo_valid = !fifo_empty;
  assign pop        = fifo_valid && bus.out_ready;
  assign {head_data, head_tag} = fifo_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      credit_q     <= CreditWidth'(FifoDepth);
      addr_q       <= '0;
      map_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      rden_q       <= 1'b0;
      rd_addr_q    <= '0;
      rd_tag_q     <= '0;
      pipe_valid_q <= 1'b0;
      pipe_tag_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rden_q       <= issue;
      done_q       <= 1'b0;
      pipe_valid_q <= rden_q;
      pipe_tag_q   <= rd_tag_q;

      if (issue) begin
        rd_addr_q <= addr_q;
        rd_tag_q  <= cur_tag;
        if (cur_tag.last) begin
          addr_q <= '0;
          map_q  <= '0;
          row_q  <= '0;
          col_q  <= '0;
        end else begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          if (col_q == POS_WIDTH'(MAP_WIDTH - 1)) begin
            col_q <= '0;
            if (row_q == POS_WIDTH'(MAP_WIDTH - 1)) begin
              row_q <= '0;
              map_q <= map_q + MAP_SEL_WIDTH'(1);
            end else begin
              row_q <= row_q + POS_WIDTH'(1);
            end
          end else begin
            col_q <= col_q + POS_WIDTH'(1);
          end
        end
      end

      if (state_q == StIdle) begin
        credit_q <= CreditWidth'(FifoDepth) - CreditWidth'(issue);
      end else begin
        credit_q <= credit_q + CreditWidth'(pop) - CreditWidth'(issue);
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= cur_tag.last ? StDrain : StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (issue && cur_tag.last) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && head_tag.last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pool_2_reader_sync_fifo_4 #(
    .Width (EntryWidth)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (pipe_valid_q),
    .wdata_i ({bus.q, pipe_tag_q}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign busy             = busy_q;
  assign done             = done_q;
  assign bus.rden         = rden_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.out_valid    = fifo_valid;
  assign bus.out_data     = fifo_valid ? head_data : '0;
  assign bus.out_map      = fifo_valid ? head_tag.map : '0;
  assign bus.out_row      = fifo_valid ? head_tag.row : '0;
  assign bus.out_col      = fifo_valid ? head_tag.col : '0;
  assign bus.out_last_map = fifo_valid && head_tag.last_map;
  assign bus.out_last     = fifo_valid && head_tag.last;

endmodule

// File: tb/tb_pool_2_reader.sv
// Scoreboard bench for pool_2_reader: one single-map and one two-map instance
// driven with randomized backpressure, checked against a per-pixel reference model.
module tb_pool_2_reader;

  localparam int W   = 6;
  localparam int PIX = W * W;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  map;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        last_map;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_a, start_b, ready;
  logic busy_a, done_a, busy_b, done_b;

  pool_2_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .MAP_SEL_WIDTH(2), .POS_WIDTH(3)) bus_a ();
  pool_2_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .MAP_SEL_WIDTH(2), .POS_WIDTH(3)) bus_b ();

  pool_2_reader #(.NUM_MAPS(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a)
  );
  pool_2_reader #(.NUM_MAPS(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b)
  );

  assign bus_a.out_ready = ready;
  assign bus_b.out_ready = ready;

  // RAM model: mem[i] = i + 100, one-cycle read latency
  always @(posedge clk) begin
    if (bus_a.rden) bus_a.q <= 16'(bus_a.rd_addr) + 16'd100;
    if (bus_b.rden) bus_b.q <= 16'(bus_b.rd_addr) + 16'd100;
  end

  beat_t      obs [2];
  logic       obs_valid [2], obs_rden [2], obs_busy [2], obs_done [2];
  logic [8:0] obs_addr [2];
  assign obs[0] = {bus_a.out_data, bus_a.out_map, bus_a.out_row, bus_a.out_col,
                   bus_a.out_last_map, bus_a.out_last};
  assign obs[1] = {bus_b.out_data, bus_b.out_map, bus_b.out_row, bus_b.out_col,
                   bus_b.out_last_map, bus_b.out_last};
  assign obs_valid[0] = bus_a.out_valid;
  assign obs_valid[1] = bus_b.out_valid;
  assign obs_rden[0]  = bus_a.rden;
  assign obs_rden[1]  = bus_b.rden;
  assign obs_addr[0]  = bus_a.rd_addr;
  assign obs_addr[1]  = bus_b.rd_addr;
  assign obs_busy[0]  = busy_a;
  assign obs_busy[1]  = busy_b;
  assign obs_done[0]  = done_a;
  assign obs_done[1]  = done_b;

  int    n_checks = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    run_start;
  beat_t exp_a [$];
  beat_t exp_b [$];
  int    exp_addr [2], rden_cnt [2], hs_cnt [2], outstanding [2], max_out [2];
  int    first_rden [2], first_valid [2], done_cyc [2], last_hs [2];
  bit    done_seen [2], prev_stall [2], busy_at_done [2], busy_after [2];
  beat_t prev_obs [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: pixel i of a run is mem[i] with indices derived by plain division.
  function automatic beat_t model_beat(input int i, input int maps);
    beat_t b;
    int p;
    p          = i % PIX;
    b.data     = 16'(i + 100);
    b.map      = 2'(i / PIX);
    b.row      = 3'(p / W);
    b.col      = 3'(p % W);
    b.last_map = (p == PIX - 1);
    b.last     = (i == maps * PIX - 1);
    return b;
  endfunction

  task automatic pop_check(input int k);
    beat_t e;
    int    sz;
    sz = (k == 0) ? exp_a.size() : exp_b.size();
    n_checks++;
    if (sz == 0) begin
      n_err++;
      $display("FAIL beat%0d: got unexpected beat %h, expected none", k, obs[k]);
    end else begin
      if (k == 0) e = exp_a.pop_front();
      else e = exp_b.pop_front();
      if (obs[k] !== e) begin
        n_err++;
        $display("FAIL beat%0d: got %h, expected %h (cycle %0d)", k, obs[k], e, cyc);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          if (k == 0) exp_a.delete();
          else exp_b.delete();
          outstanding[k] = 0;
          prev_stall[k]  = 1'b0;
        end else begin
          if (obs_rden[k]) begin
            chk($sformatf("rd_addr%0d", k), 64'(obs_addr[k]), 64'(exp_addr[k]));
            exp_addr[k]++;
            rden_cnt[k]++;
            outstanding[k]++;
            if (first_rden[k] < 0) first_rden[k] = cyc;
          end
          if (obs_valid[k]) begin
            if (first_valid[k] < 0) first_valid[k] = cyc;
            if (prev_stall[k]) chk($sformatf("stall_hold%0d", k), 64'(obs[k]), 64'(prev_obs[k]));
          end else begin
            chk($sformatf("idle_zero%0d", k), 64'(obs[k]), 64'd0);
          end
          if (obs_valid[k] && ready) begin
            pop_check(k);
            hs_cnt[k]++;
            outstanding[k]--;
            if (obs[k].last) last_hs[k] = cyc;
          end
          if (outstanding[k] > max_out[k]) max_out[k] = outstanding[k];
          if (obs_done[k]) begin
            done_seen[k]    = 1'b1;
            done_cyc[k]     = cyc;
            busy_at_done[k] = obs_busy[k];
          end
          if (done_seen[k] && cyc == done_cyc[k] + 1) busy_after[k] = obs_busy[k];
          prev_stall[k] = obs_valid[k] && !ready;
          prev_obs[k]   = obs[k];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_run(input int k);
    exp_addr[k]    = 0;
    rden_cnt[k]    = 0;
    hs_cnt[k]      = 0;
    max_out[k]     = 0;
    first_rden[k]  = -1;
    first_valid[k] = -1;
    done_cyc[k]    = -1;
    last_hs[k]     = -1;
    done_seen[k]   = 1'b0;
    busy_after[k]  = 1'b1;
  endtask

  task automatic start_run(input bit do_a, input bit do_b);
    if (do_a) begin
      clear_run(0);
      for (int i = 0; i < PIX; i++) exp_a.push_back(model_beat(i, 1));
      start_a = 1'b1;
    end
    if (do_b) begin
      clear_run(1);
      for (int i = 0; i < 2 * PIX; i++) exp_b.push_back(model_beat(i, 2));
      start_b = 1'b1;
    end
    run_start = cyc;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // mode 0: ready high; 1: toggle, hold low, then random, with ignored starts; 2: random
  task automatic drive_until_done(input int mode, input bit need_a, input bit need_b,
                                  input int limit);
    int t;
    t = 1;
    while (((need_a && !done_seen[0]) || (need_b && !done_seen[1])) && t < limit) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (t < 30) ? (t % 2 == 1) : (t < 40) ? 1'b0 : 1'($urandom_range(0, 1));
        default: ready = ($urandom_range(0, 3) != 0);
      endcase
      start_a = (mode == 1) && (t == 5 || t == 20);
      start_b = start_a;
      tick();
      t++;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    if (need_a) chk("done_a_timeout", 64'(done_seen[0]), 64'd1);
    if (need_b) chk("done_b_timeout", 64'(done_seen[1]), 64'd1);
    repeat (2) tick();
  endtask

  task automatic check_counts(input int k, input int n);
    chk($sformatf("rden_count%0d", k), 64'(rden_cnt[k]), 64'(n));
    chk($sformatf("beat_count%0d", k), 64'(hs_cnt[k]), 64'(n));
    chk($sformatf("queue_left%0d", k), 64'((k == 0) ? exp_a.size() : exp_b.size()), 64'd0);
    chk($sformatf("busy_at_done%0d", k), 64'(busy_at_done[k]), 64'd1);
    chk($sformatf("busy_after_done%0d", k), 64'(busy_after[k]), 64'd0);
  endtask

  task automatic check_idle_a(input string name);
    @(negedge clk);
    chk(name, {busy_a, done_a, bus_a.rden, bus_a.rd_addr, bus_a.out_valid, obs[0]}, 64'd0);
  endtask

  initial begin
    int t;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    ready   = 1'b1;
    clear_run(0);
    clear_run(1);
    outstanding[0] = 0;
    outstanding[1] = 0;
    repeat (3) tick();
    reset = 1'b0;
    check_idle_a("reset_state_a");
    chk("reset_state_b", {busy_b, done_b, bus_b.rden, bus_b.rd_addr, bus_b.out_valid, obs[1]}, 64'd0);
    tick();

    // Run 1: full throughput, exact cycle timing
    ready = 1'b1;
    start_run(1'b1, 1'b1);
    drive_until_done(0, 1'b1, 1'b1, 300);
    chk("first_rden_cycle_a", 64'(first_rden[0]), 64'(run_start + 1));
    chk("first_valid_cycle_a", 64'(first_valid[0]), 64'(run_start + 3));
    chk("last_beat_cycle_a", 64'(last_hs[0]), 64'(run_start + PIX + 2));
    chk("done_cycle_a", 64'(done_cyc[0]), 64'(run_start + PIX + 3));
    chk("last_beat_cycle_b", 64'(last_hs[1]), 64'(run_start + 2 * PIX + 2));
    chk("done_cycle_b", 64'(done_cyc[1]), 64'(run_start + 2 * PIX + 3));
    check_counts(0, PIX);
    check_counts(1, 2 * PIX);

    // Run 2: backpressure with starts pulsed while busy
    start_run(1'b1, 1'b1);
    drive_until_done(1, 1'b1, 1'b1, 1500);
    check_counts(0, PIX);
    check_counts(1, 2 * PIX);
    chk("max_outstanding_a", 64'(max_out[0]), 64'd4);
    chk("max_outstanding_b", 64'(max_out[1]), 64'd4);

    // Run 3: start pulsed in the DONE cycle must be ignored
    start_run(1'b1, 1'b0);
    t = 0;
    while (!done_a && t < 500) begin
      ready = ($urandom_range(0, 3) != 0);
      tick();
      t++;
    end
    chk("done_a_timeout", 64'(done_a), 64'd1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3) tick();
    chk("start_in_done_busy", 64'(busy_a), 64'd0);
    check_counts(0, PIX);

    // Run 4: a fresh start after done restarts at address 0
    start_run(1'b1, 1'b0);
    drive_until_done(2, 1'b1, 1'b0, 500);
    chk("restart_first_rden_a", 64'(first_rden[0]), 64'(run_start + 1));
    check_counts(0, PIX);

    // Run 5: reset while beat 10 is presented, then restart
    ready = 1'b1;
    start_run(1'b1, 1'b0);
    t = 0;
    while (hs_cnt[0] != 9 && t < 100) begin
      tick();
      t++;
    end
    chk("reach_beat10", 64'(hs_cnt[0]), 64'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_a("midreset_state_a");
    tick();
    check_idle_a("midreset_discard_a");
    tick();
    start_run(1'b1, 1'b0);
    drive_until_done(0, 1'b1, 1'b0, 300);
    chk("post_reset_first_rden_a", 64'(first_rden[0]), 64'(run_start + 1));
    check_counts(0, PIX);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pool_2_reader.md
# pool_2_reader

Drains the pooled feature maps left by the second pooling stage out of its shared dual-port RAM and streams them to the next layer.
- Reads only through the RAM's port b; the pooling stage owns port a.
- Each pixel leaves on a valid/ready stream tagged with map, row and column indices.
- A 4-entry output FIFO absorbs the RAM read latency under backpressure.

## Interface
Parameters:
- DATA_WIDTH, 16, pixel width
- MAP_WIDTH, 6, pooled map side length W (maps are W×W)
- NUM_MAPS, 1, number of maps stored back-to-back in the RAM
- ADDR_WIDTH, 9, RAM address width; NUM_MAPS·W·W ≤ 2^ADDR_WIDTH is required
- MAP_SEL_WIDTH, 2, width of out_map
- POS_WIDTH, 3, width of out_row and out_col

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- start  in  1  one-cycle pulse; accepted only in IDLE
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- rden  out  1  port-b read enable, registered
- rd_addr  out  ADDR_WIDTH  port-b address, registered
- q  in  DATA_WIDTH  port-b read data, valid one cycle after rden
- out_data  out  DATA_WIDTH  pixel
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_map  out  MAP_SEL_WIDTH  map index of the beat
- out_row  out  POS_WIDTH  row index of the beat
- out_col  out  POS_WIDTH  column index of the beat
- out_last_map  out  1  beat is the last pixel of a map
- out_last  out  1  beat is the last pixel of the last map
- done  out  1  one-cycle pulse after the final beat handshakes

## Operation
FSM states:
- IDLE → RUN on start.
- RUN → DRAIN when the final read is issued.
- DRAIN → DONE on the handshake of the beat with out_last.
- DONE → IDLE unconditionally after one cycle.

Issue rules:
- Reads are issued in RUN only, one per cycle, when credit > 0.
- credit resets to 4 on entry to RUN (equal to the FIFO depth).
- credit is decremented on each issue and incremented on each output handshake; both in one cycle leave it unchanged.

Address and index generation:
- The address counter starts at 0 and increments by 1 per issue.
- Row/col/map counters travel with each read: col wraps at W-1 → 0 and advances row; row wraps at W-1 → 0 and advances map.
- Tags are pipelined alongside the read, so tag width never depends on the RAM.

FIFO behaviour:
- An entry is written one cycle after its rden, holding {q, map, row, col, last_map, last}.
- The head drives the out_* signals.
- A stalled output (out_valid=1, out_ready=0) holds every out_* field stable.

Reset values (all outputs 0):
- busy, rden, rd_addr, out_valid, done are 0, the FIFO is empty, state is IDLE.
- out_data and the tag outputs are 0 while out_valid is 0.

Boundary conditions:
- start while busy: ignored, no effect on counters.
- start in the DONE cycle: ignored.
- reset mid-stream: next cycle equals the reset state; in-flight read data returning after reset is discarded.
- A push and a pop in the same cycle on a full FIFO is legal; overflow is impossible by construction of the credit scheme.
- out_last and out_last_map are both set on the final beat.

## Timing
The cycle in which start is sampled is cycle 0.
- Cycle 1: rden=1, rd_addr=0.
- Cycle 2: q carries mem[0] and is written into the FIFO.
- Cycle 3: out_valid=1 with mem[0].
- With out_ready held high: one beat per cycle with no bubbles; beat n appears at cycle n+2 (n from 1).
- rden spans cycles 1..N, where N = NUM_MAPS·W·W.
- The final beat handshakes at cycle N+2; done=1 and busy=1 at cycle N+3; busy=0 at cycle N+4.
- Under backpressure, at most 4 reads are ever outstanding (in flight plus queued).

## Structure
Shared package holds:
- FSM state encoding (IDLE, RUN, DRAIN, DONE)
- FIFO depth constant 4
- a clog2 helper for credit and occupancy widths

Sub-module sync_fifo_4:
- depth 4, width DATA_WIDTH + MAP_SEL_WIDTH + 2·POS_WIDTH + 2
- show-ahead head, full/empty flags, synchronous reset

## Test plan
- Defaults (W=6, N=1), RAM model with mem[i]=i+100, out_ready=1 → rden at cycles 1..36 with addresses 0..35; 36 consecutive beats with data 100..135; row/col walk (0,0)..(5,5); out_last on beat 36; done at cycle 39.
- Backpressure: out_ready toggles 1,0 every cycle, then is held low for 10 cycles mid-stream → all 36 values appear in order with no duplicates; out_data stays stable while stalled; rden stops after 4 outstanding reads.
- NUM_MAPS=2 → addresses 0..71; out_map changes 0→1 on beat 37; out_last_map on beats 36 and 72; out_last only on beat 72.
- start pulsed at cycles 5 and 20 of a run → ignored, beat count stays 36; start issued after done → new run begins at address 0.
- reset asserted when beat 10 is presented → next cycle all outputs are 0 and the FIFO is empty; a following start yields rd_addr=0 and first data mem[0].
